// File: rtl/gravsim_datafile_if.sv
`default_nettype none
// ============================================================================
//  Module   : gravsim_datafile_if
//  Purpose  : Avalon-MM slave bundle between the host and the gravity
//             simulator register file.
//  Signals  : avl_cs/avl_read/avl_write  host strobes
//             avl_addr       7-bit word address
//             avl_writedata  32-bit host write data
//             avl_byte_en    4 byte-lane enables
//             avl_readdata   32-bit registered read data (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface gravsim_datafile_if;
    logic        avl_cs;
    logic        avl_read;
    logic        avl_write;
    logic [6:0]  avl_addr;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byte_en;
    logic [31:0] avl_readdata;

    modport master (
        output avl_cs, avl_read, avl_write, avl_addr, avl_writedata, avl_byte_en,
        input  avl_readdata
    );

    modport slave (
        input  avl_cs, avl_read, avl_write, avl_addr, avl_writedata, avl_byte_en,
        output avl_readdata
    );
endinterface
`default_nettype wire

// File: rtl/gravsim_datafile.sv
`default_nettype none
// ============================================================================
//  Module   : gravsim_datafile
//  Purpose  : Word-addressed register file for the gravity simulator. Holds G,
//             the body count and per-body mass/radius/pos/vel/acc words, serves
//             host accesses, commits the physics FSM's dual write-back bursts
//             and runs the START/DONE run-control handshake.
//  Ports    : clk, rst_n            clock, asynchronous active-low reset
//             avl                   Avalon-MM slave (host access)
//             datafile              every word in parallel, from storage
//             fsm_start             high exactly while a run is in progress
//             fsm_done              run-complete from the physics FSM
//             clear_accs            zero all acceleration words
//             fsm_we[1:0]           bit0 commits lanes 1-3, bit1 lanes 4-6
//             addr1..6 / data1..6   FSM write-back lanes
//  Revision : 1.0  initial release
// ============================================================================
module gravsim_datafile #(
    parameter int WORDS      = 114,
    parameter int MAX_BODIES = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gravsim_datafile_if.slave       avl,
    output logic [WORDS-1:0][31:0]  datafile,
    output logic                    fsm_start,
    input  logic                    fsm_done,
    input  logic                    clear_accs,
    input  logic [1:0]              fsm_we,
    input  logic [31:0]             addr1,
    input  logic [31:0]             addr2,
    input  logic [31:0]             addr3,
    input  logic [31:0]             addr4,
    input  logic [31:0]             addr5,
    input  logic [31:0]             addr6,
    input  logic [31:0]             data1,
    input  logic [31:0]             data2,
    input  logic [31:0]             data3,
    input  logic [31:0]             data4,
    input  logic [31:0]             data5,
    input  logic [31:0]             data6
);

    localparam int c_NUM_ADDR   = 1;
    localparam int c_START_ADDR = 2;
    localparam int c_DONE_ADDR  = 3;
    localparam int c_BODY_BASE  = 4;
    localparam int c_ACC_BASE   = 84;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_readdata;

    logic [31:0] w_byte_mask;
    logic        w_host_wr;
    logic        w_host_rd;
    logic        w_ctrl_wr;
    logic        w_ctrl_nz;
    logic        w_data_wr_ok;
    logic [5:0]  w_lane_en;
    logic [31:0] w_lane_addr [6];
    logic [31:0] w_lane_data [6];

    assign w_byte_mask  = {{8{avl.avl_byte_en[3]}}, {8{avl.avl_byte_en[2]}},
                           {8{avl.avl_byte_en[1]}}, {8{avl.avl_byte_en[0]}}};
    assign w_host_wr    = avl.avl_cs && avl.avl_write;
    assign w_host_rd    = avl.avl_cs && avl.avl_read;
    assign w_ctrl_wr    = w_host_wr && (avl.avl_addr == 7'(c_START_ADDR));
    // START has no storage, so "nonzero" is judged on the enabled lanes only.
    assign w_ctrl_nz    = |(avl.avl_writedata & w_byte_mask);
    // Host data writes are locked out while the physics FSM owns the file.
    assign w_data_wr_ok = w_host_wr && (r_state != S_RUN);

    assign w_lane_en   = {{3{fsm_we[1]}}, {3{fsm_we[0]}}};
    assign w_lane_addr = '{addr1, addr2, addr3, addr4, addr5, addr6};
    assign w_lane_data = '{data1, data2, data3, data4, data5, data6};

    // ------------------------------------------------------------------
    // Run-control FSM. A host write to START always decides the next state
    // (nonzero -> RUN, zero -> IDLE); DONE only matters while running.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ctrl_wr && w_ctrl_nz) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_ctrl_wr) begin
                    w_state_next = w_ctrl_nz ? S_RUN : S_IDLE;
                end else if (fsm_done) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                if (w_ctrl_wr) begin
                    w_state_next = w_ctrl_nz ? S_RUN : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign fsm_start = (r_state == S_RUN);

    // ------------------------------------------------------------------
    // Word storage. START/DONE are decoded from the FSM state; every other
    // word is a register whose next value applies host, then FSM lanes in
    // ascending order (so the highest lane wins), then the acc clear.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        if (gi == c_START_ADDR) begin : g_start
            assign datafile[gi] = {31'd0, r_state == S_RUN};
        end else if (gi == c_DONE_ADDR) begin : g_done
            assign datafile[gi] = {31'd0, r_state == S_FIN};
        end else begin : g_store
            logic [31:0] r_word;
            logic [31:0] w_merged;
            logic [31:0] w_next;

            always_comb begin
                w_merged = (r_word & ~w_byte_mask) | (avl.avl_writedata & w_byte_mask);
                // Body count is clamped on the fully merged word.
                if (gi == c_NUM_ADDR && w_merged > 32'(MAX_BODIES)) begin
                    w_merged = 32'(MAX_BODIES);
                end

                w_next = r_word;
                if (w_data_wr_ok && avl.avl_addr == 7'(gi)) begin
                    w_next = w_merged;
                end
                // G and NUM are host-only; lanes aimed at them are ignored.
                if (gi >= c_BODY_BASE) begin
                    for (int k = 0; k < 6; k++) begin
                        if (w_lane_en[k] && w_lane_addr[k] == 32'(gi)) begin
                            w_next = w_lane_data[k];
                        end
                    end
                end
                if (gi >= c_ACC_BASE && clear_accs) begin
                    w_next = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_word <= '0;
                end else begin
                    r_word <= w_next;
                end
            end

            assign datafile[gi] = r_word;
        end
    end

    // Registered host read; sampling before the edge gives old-value
    // semantics on read-during-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_readdata <= '0;
        end else if (w_host_rd) begin
            r_readdata <= (avl.avl_addr < 7'(WORDS)) ? datafile[avl.avl_addr] : '0;
        end
    end

    assign avl.avl_readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_gravsim_datafile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gravsim_datafile
//  Purpose  : Self-checking bench for gravsim_datafile: directed scenarios
//             plus randomized host/FSM traffic against a word-array model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gravsim_datafile;

    localparam int WORDS = 114;
    localparam int MAXB  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    gravsim_datafile_if avl();
    logic [WORDS-1:0][31:0] datafile;
    logic        fsm_start;
    logic        fsm_done;
    logic        clear_accs;
    logic [1:0]  fsm_we;
    logic [31:0] addr [6];
    logic [31:0] data [6];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain word array plus run state (0 idle, 1 run, 2 fin)
    logic [31:0] m_mem [WORDS];
    int          m_state;
    logic [31:0] m_rd;

    gravsim_datafile #(.WORDS(WORDS), .MAX_BODIES(MAXB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .avl        (avl),
        .datafile   (datafile),
        .fsm_start  (fsm_start),
        .fsm_done   (fsm_done),
        .clear_accs (clear_accs),
        .fsm_we     (fsm_we),
        .addr1      (addr[0]),
        .addr2      (addr[1]),
        .addr3      (addr[2]),
        .addr4      (addr[3]),
        .addr5      (addr[4]),
        .addr6      (addr[5]),
        .data1      (data[0]),
        .data2      (data[1]),
        .data3      (data[2]),
        .data4      (data[3]),
        .data5      (data[4]),
        .data6      (data[5])
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input int a);
        if (a == 2) return (m_state == 1) ? 32'd1 : 32'd0;
        if (a == 3) return (m_state == 2) ? 32'd1 : 32'd0;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
        m_state = 0;
        m_rd    = '0;
    endtask

    task automatic check_all();
        check_value("readdata", avl.avl_readdata, m_rd);
        check_value("fsm_start", {31'd0, fsm_start}, (m_state == 1) ? 32'd1 : 32'd0);
        for (int i = 0; i < WORDS; i++) begin
            check_value($sformatf("word%0d", i), datafile[i], m_word(i));
        end
    endtask

    task automatic clear_inputs();
        avl.avl_cs        = 1'b0;
        avl.avl_read      = 1'b0;
        avl.avl_write     = 1'b0;
        avl.avl_addr      = '0;
        avl.avl_writedata = '0;
        avl.avl_byte_en   = 4'hF;
        fsm_done          = 1'b0;
        clear_accs        = 1'b0;
        fsm_we            = 2'b00;
        for (int k = 0; k < 6; k++) begin
            addr[k] = '0;
            data[k] = '0;
        end
    endtask

    // One clock: predict from the current inputs, take the edge, compare.
    task automatic tick();
        logic [31:0] nm [WORDS];
        int          ns;
        logic [31:0] nrd;
        logic [31:0] mask;
        logic [31:0] merged;
        int          a;
        nm   = m_mem;
        ns   = m_state;
        nrd  = m_rd;
        mask = {{8{avl.avl_byte_en[3]}}, {8{avl.avl_byte_en[2]}},
                {8{avl.avl_byte_en[1]}}, {8{avl.avl_byte_en[0]}}};
        if (avl.avl_cs && avl.avl_read)
            nrd = (avl.avl_addr < WORDS) ? m_word(int'(avl.avl_addr)) : 32'd0;
        a = int'(avl.avl_addr);
        if (avl.avl_cs && avl.avl_write && a == 2) begin
            ns = ((avl.avl_writedata & mask) != 0) ? 1 : 0;
        end else begin
            if (m_state == 1 && fsm_done) ns = 2;
            if (avl.avl_cs && avl.avl_write && a < WORDS && a != 3 && m_state != 1) begin
                merged = (m_mem[a] & ~mask) | (avl.avl_writedata & mask);
                if (a == 1 && merged > MAXB) merged = MAXB;
                nm[a] = merged;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (fsm_we[k / 3] && addr[k] >= 4 && addr[k] < WORDS)
                nm[int'(addr[k])] = data[k];
        end
        if (clear_accs)
            for (int i = 84; i < WORDS; i++) nm[i] = '0;
        @(posedge clk);
        #1;
        m_mem   = nm;
        m_state = ns;
        m_rd    = nrd;
        check_all();
    endtask

    task automatic host_write(input int a, input logic [31:0] d, input logic [3:0] be);
        avl.avl_cs        = 1'b1;
        avl.avl_write     = 1'b1;
        avl.avl_addr      = 7'(a);
        avl.avl_writedata = d;
        avl.avl_byte_en   = be;
        tick();
        avl.avl_cs        = 1'b0;
        avl.avl_write     = 1'b0;
        avl.avl_byte_en   = 4'hF;
    endtask

    task automatic host_read(input int a);
        avl.avl_cs   = 1'b1;
        avl.avl_read = 1'b1;
        avl.avl_addr = 7'(a);
        tick();
        avl.avl_cs   = 1'b0;
        avl.avl_read = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();

        // Basic host writes and reads
        host_write(0, 32'h40800000, 4'hF);
        host_write(1, 32'd2, 4'hF);
        host_write(24, 32'h3F800000, 4'hF);
        host_write(25, 32'hBF800000, 4'hF);
        host_read(0);  check_value("rd_g", avl.avl_readdata, 32'h40800000);
        host_read(1);  check_value("rd_num", avl.avl_readdata, 32'd2);
        host_read(24); check_value("rd_pos1", avl.avl_readdata, 32'h3F800000);
        host_read(25); check_value("rd_pos2", avl.avl_readdata, 32'hBF800000);
        host_read(3);  check_value("rd_done0", avl.avl_readdata, 32'd0);

        // Clamp, out-of-range, byte lanes
        host_write(1, 32'd37, 4'hF);
        host_read(1);  check_value("rd_clamp", avl.avl_readdata, 32'd10);
        host_write(120, 32'h12345678, 4'hF);
        host_read(120); check_value("rd_oor", avl.avl_readdata, 32'd0);
        host_write(4, 32'hAABBCCDD, 4'b0101);
        host_read(4);  check_value("rd_bytes", avl.avl_readdata, 32'h00BB00DD);

        // Run handshake
        host_write(2, 32'd1, 4'hF);
        check_value("start_hi", {31'd0, fsm_start}, 32'd1);
        host_write(24, 32'd5, 4'hF);
        host_read(24); check_value("run_drop", avl.avl_readdata, 32'h3F800000);
        fsm_we = 2'b01; addr[0] = 32'd84; data[0] = 32'h3F800000;
        tick();
        fsm_we = 2'b00;
        check_value("fsm_wr84", datafile[84], 32'h3F800000);
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        check_value("done_word", datafile[3], 32'd1);
        check_value("done_start", {31'd0, fsm_start}, 32'd0);
        host_write(2, 32'd0, 4'hF);
        check_value("fin_clear", datafile[3], 32'd0);

        // Lane priority and acc clear
        fsm_we = 2'b11; addr[0] = 32'd30; data[0] = 32'd1; addr[4] = 32'd30; data[4] = 32'd2;
        tick();
        clear_inputs();
        check_value("lane_prio", datafile[30], 32'd2);
        fsm_we = 2'b01; addr[0] = 32'd90; data[0] = 32'd7; addr[1] = 32'd40; data[1] = 32'd7;
        clear_accs = 1'b1;
        tick();
        clear_inputs();
        check_value("clr_acc90", datafile[90], 32'd0);
        check_value("clr_keep40", datafile[40], 32'd7);

        // Reset in the middle of a run
        host_write(2, 32'd1, 4'hF);
        fsm_we = 2'b01; addr[0] = 32'd84; data[0] = 32'h00001234;
        tick();
        clear_inputs();
        host_read(24); check_value("pre_rst_rd", avl.avl_readdata, 32'h3F800000);
        #2 rst_n = 1'b0;
        #1;
        check_value("rst_start", {31'd0, fsm_start}, 32'd0);
        check_value("rst_rd", avl.avl_readdata, 32'd0);
        check_value("rst_w24", datafile[24], 32'd0);
        check_value("rst_w84", datafile[84], 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();
        host_read(24); check_value("post_rst_rd", avl.avl_readdata, 32'd0);

        // DONE outside RUN, abort keeps results
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        check_value("idle_done", datafile[3], 32'd0);
        host_write(2, 32'd1, 4'hF);
        fsm_we = 2'b10; addr[3] = 32'd50; data[3] = 32'hCAFEF00D;
        tick();
        clear_inputs();
        host_write(2, 32'd0, 4'hF);
        check_value("abort_start", {31'd0, fsm_start}, 32'd0);
        check_value("abort_keep", datafile[50], 32'hCAFEF00D);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            avl.avl_cs    = ($urandom % 4) != 0;
            avl.avl_read  = $urandom % 2;
            avl.avl_write = ($urandom % 3) == 0;
            if ($urandom % 10 == 0) begin
                avl.avl_addr      = 7'd2;
                avl.avl_writedata = $urandom % 2;
                avl.avl_byte_en   = 4'hF;
            end else begin
                avl.avl_addr      = 7'($urandom % 128);
                avl.avl_writedata = ($urandom % 4 == 0) ? ($urandom % 16) : $urandom;
                avl.avl_byte_en   = 4'($urandom);
            end
            fsm_we = 2'($urandom);
            for (int k = 0; k < 6; k++) begin
                addr[k] = ($urandom % 4 == 0) ? addr[0] : ($urandom % 124);
                data[k] = $urandom;
            end
            fsm_done   = ($urandom % 8) == 0;
            clear_accs = ($urandom % 16) == 0;
            tick();
        end
        clear_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
